// File: rtl/trap_seq.sv
// trap_seq: WB-stage trap entry sequencer. It flushes the pipeline, pulses the CSR
// trap write, hands the trap vector to fetch, then masks interrupts for a short settle window.
`default_nettype none

module trap_seq #(
    parameter int PC_SZ      = 32,
    parameter int RSZ        = 32,
    parameter int SETTLE_CYC = 2
) (
    input  logic               clk_in,
    input  logic               reset_n_in,
    input  logic               exception_flag,
    input  logic [3:0]         exception_cause,
    input  logic [PC_SZ-1:0]   exception_pc,
    input  logic [RSZ-1:0]     exception_tval,
    input  logic               interrupt_flag,
    input  logic [3:0]         interrupt_cause,
    input  logic               wb_valid,
    input  logic [PC_SZ-1:0]   wb_pc,
    input  logic [PC_SZ-3:0]   trap_pc,
    input  logic [1:0]         mode,
    input  logic [1:0]         nxt_mode,
    output logic               flush_req,
    input  logic               flush_ack,
    output logic               csr_trap_we,
    output logic [1:0]         csr_trap_mode,
    output logic [1:0]         csr_prev_mode,
    output logic [PC_SZ-1:0]   csr_epc,
    output logic [RSZ-1:0]     csr_cause,
    output logic [RSZ-1:0]     csr_tval,
    output logic               redirect_valid,
    input  logic               redirect_ready,
    output logic [PC_SZ-1:0]   redirect_pc,
    output logic               irq_mask,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        REDIRECT = 2'd2,
        SETTLE   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYC);

    state_t             state;
    logic [3:0]         settle_cnt;
    logic [RSZ-1:0]     cap_cause;
    logic [RSZ-1:0]     cap_tval;
    logic [PC_SZ-1:0]   cap_epc;
    logic [PC_SZ-3:0]   cap_tpc;
    logic [1:0]         cap_nxt_mode;
    logic [1:0]         cap_mode;

    // SETTLE still admits exceptions (they must not be lost) but keeps interrupts out.
    logic take_exc;
    logic take_irq;
    logic accept;

    assign take_exc = exception_flag && ((state == IDLE) || (state == SETTLE));
    assign take_irq = interrupt_flag && wb_valid && (state == IDLE);
    assign accept   = take_exc || take_irq;

    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            state          <= IDLE;
            settle_cnt     <= '0;
            cap_cause      <= '0;
            cap_tval       <= '0;
            cap_epc        <= '0;
            cap_tpc        <= '0;
            cap_nxt_mode   <= '0;
            cap_mode       <= '0;
            flush_req      <= 1'b0;
            csr_trap_we    <= 1'b0;
            csr_trap_mode  <= '0;
            csr_prev_mode  <= '0;
            csr_epc        <= '0;
            csr_cause      <= '0;
            csr_tval       <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            irq_mask       <= 1'b0;
            busy           <= 1'b0;
        end else begin
            csr_trap_we <= 1'b0;
            if (accept) begin
                state        <= FLUSH;
                settle_cnt   <= '0;
                flush_req    <= 1'b1;
                irq_mask     <= 1'b1;
                busy         <= 1'b1;
                cap_tpc      <= trap_pc;
                cap_nxt_mode <= nxt_mode;
                cap_mode     <= mode;
                if (take_exc) begin
                    cap_cause <= {1'b0, {(RSZ-5){1'b0}}, exception_cause};
                    cap_epc   <= exception_pc;
                    cap_tval  <= exception_tval;
                end else begin
                    cap_cause <= {1'b1, {(RSZ-5){1'b0}}, interrupt_cause};
                    cap_epc   <= wb_pc;
                    cap_tval  <= '0;
                end
            end else begin
                case (state)
                    FLUSH: begin
                        if (flush_ack) begin
                            state          <= REDIRECT;
                            flush_req      <= 1'b0;
                            csr_trap_we    <= 1'b1;
                            csr_trap_mode  <= cap_nxt_mode;
                            csr_prev_mode  <= cap_mode;
                            csr_epc        <= cap_epc;
                            csr_cause      <= cap_cause;
                            csr_tval       <= cap_tval;
                            redirect_valid <= 1'b1;
                            redirect_pc    <= {cap_tpc, 2'b00};
                        end
                    end
                    REDIRECT: begin
                        if (redirect_ready) begin
                            redirect_valid <= 1'b0;
                            settle_cnt     <= SETTLE_INIT;
                            state          <= SETTLE;
                        end
                    end
                    SETTLE: begin
                        settle_cnt <= settle_cnt - 4'd1;
                        if (settle_cnt <= 4'd1) begin
                            state    <= IDLE;
                            irq_mask <= 1'b0;
                            busy     <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

`default_nettype wire
